// File: rtl/matmul_tile_sequencer_if.sv
// Bundled command/operand/MAC/result handshakes of the matmul tile sequencer.
// The slave modport is the sequencer side; master is the host/MAC environment side.
interface matmul_tile_sequencer_if #(
  parameter int unsigned M  = 2,
  parameter int unsigned N  = 2,
  parameter int unsigned K  = 2,
  parameter int unsigned P  = 8,
  parameter int unsigned CW = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CW-1:0]        cmd_ktiles;
  logic                 op_valid;
  logic                 op_ready;
  logic [M*K*P-1:0]     op_a;
  logic [K*N*P-1:0]     op_b;
  logic [CW-1:0]        tile_idx;
  logic                 mac_valid_in;
  logic                 mac_ready_in;
  logic [M*K*P-1:0]     mac_a;
  logic [K*N*P-1:0]     mac_b;
  logic [M*N*4*P-1:0]   mac_c;
  logic                 mac_valid_out;
  logic                 mac_ready_out;
  logic [M*N*4*P-1:0]   mac_d;
  logic                 res_valid;
  logic                 res_ready;
  logic [M*N*4*P-1:0]   res_d;
  logic                 busy;

  modport slave (
    input  cmd_valid, cmd_ktiles, op_valid, op_a, op_b,
           mac_ready_in, mac_valid_out, mac_d, res_ready,
    output cmd_ready, op_ready, tile_idx, mac_valid_in, mac_a, mac_b, mac_c,
           mac_ready_out, res_valid, res_d, busy
  );

  modport master (
    output cmd_valid, cmd_ktiles, op_valid, op_a, op_b,
           mac_ready_in, mac_valid_out, mac_d, res_ready,
    input  cmd_ready, op_ready, tile_idx, mac_valid_in, mac_a, mac_b, mac_c,
           mac_ready_out, res_valid, res_d, busy
  );
endinterface

// File: rtl/matmul_tile_sequencer.sv
// Sequences K-tile operand pairs through an external MAC, feeding each D back as
// the next C, and returns the accumulated tile once all K-tiles are consumed.
module matmul_tile_sequencer #(
  parameter int unsigned M  = 2,
  parameter int unsigned N  = 2,
  parameter int unsigned K  = 2,
  parameter int unsigned P  = 8,
  parameter int unsigned CW = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  matmul_tile_sequencer_if.slave   bus
);
  localparam int unsigned AW = M*N*4*P;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [AW-1:0]      r_acc;
  logic [CW-1:0]      r_tile_cnt;
  logic [CW-1:0]      r_ktiles;
  logic [CW-1:0]      w_cnt_inc;
  logic [M*K*P-1:0]   w_a;
  logic [K*N*P-1:0]   w_b;
  logic               w_cmd_ready;
  logic               w_cmd_hs;
  logic               w_mac_ready_out;
  logic               w_d_load;

  assign w_cnt_inc = r_tile_cnt + CW'(1);
  assign w_a       = bus.op_a;
  assign w_b       = bus.op_b;

  // Operands and accumulator go straight to the MAC; only the handshakes are state-gated.
  assign bus.mac_a    = w_a;
  assign bus.mac_b    = w_b;
  assign bus.mac_c    = r_acc;
  assign bus.res_d    = r_acc;
  assign bus.tile_idx = r_tile_cnt;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.cmd_ready     = w_cmd_ready;
  assign bus.mac_ready_out = w_mac_ready_out;

  assign w_cmd_hs = w_cmd_ready && bus.cmd_valid;
  assign w_d_load = w_mac_ready_out && bus.mac_valid_out;

  always_comb begin
    w_state_nxt      = r_state;
    w_cmd_ready      = 1'b0;
    w_mac_ready_out  = 1'b0;
    bus.op_ready     = 1'b0;
    bus.mac_valid_in = 1'b0;
    bus.res_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Reset parks the FSM in IDLE, so command acceptance is also masked by rst_i.
        w_cmd_ready = !rst_i;
        if (bus.cmd_valid && !rst_i)
          w_state_nxt = (bus.cmd_ktiles == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        bus.mac_valid_in = bus.op_valid;
        bus.op_ready     = bus.mac_ready_in;
        if (bus.op_valid && bus.mac_ready_in)
          w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_mac_ready_out = 1'b1;
        if (bus.mac_valid_out)
          w_state_nxt = (w_cnt_inc == r_ktiles) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_tile_cnt <= '0;
      r_ktiles   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_hs) begin
        r_ktiles   <= bus.cmd_ktiles;
        r_acc      <= '0;
        r_tile_cnt <= '0;
      end else if (w_d_load) begin
        r_acc      <= bus.mac_d;
        r_tile_cnt <= w_cnt_inc;
      end
    end
  end
endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Directed bench for matmul_tile_sequencer with a behavioural MAC of programmable latency.
module tb_matmul_tile_sequencer;
  localparam int unsigned M = 2, N = 2, K = 2, P = 8, CW = 8;

  localparam logic [31:0]  A_T = 32'h04030201;  // [[1,2],[3,4]]
  localparam logic [31:0]  B_T = 32'h08070605;  // [[5,6],[7,8]]
  localparam logic [127:0] D1  = {32'd50,  32'd43,  32'd22, 32'd19};
  localparam logic [127:0] D2  = {32'd100, 32'd86,  32'd44, 32'd38};
  localparam logic [127:0] D3  = {32'd150, 32'd129, 32'd66, 32'd57};

  logic clk = 1'b0;
  logic rst = 1'b0;

  matmul_tile_sequencer_if #(.M(M), .N(N), .K(K), .P(P), .CW(CW)) bus ();

  matmul_tile_sequencer #(.M(M), .N(N), .K(K), .P(P), .CW(CW)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // environment knobs
  int          mac_lat      = 0;
  int          mac_stall    = 0;
  int          res_hold     = 0;
  bit          op_rand      = 0;
  bit          early_en     = 0;
  logic [7:0]  early_kt     = '0;
  int          abort_issues = 0;

  // MAC model state
  bit           pend     = 0;
  int           pend_cnt = 0;
  logic [127:0] pend_d   = '0;

  // per-job observations
  int           n_op, n_vin, n_issue, n_overlap, n_resv, n_hold, n_res_cmd;
  int           acc_cyc, res_cyc;
  bit           done;
  logic [127:0] res_cap;
  logic [127:0] c_log[$];
  logic [7:0]   idx_log[$];

  function automatic logic [127:0] mac_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [127:0] c);
    logic [127:0] d;
    d = c;
    for (int r = 0; r < 2; r++)
      for (int cc = 0; cc < 2; cc++) begin
        logic [31:0] s;
        s = c[(r*2+cc)*32 +: 32];
        for (int k = 0; k < 2; k++)
          s = s + 32'(a[(r*2+k)*8 +: 8]) * 32'(b[(k*2+cc)*8 +: 8]);
        d[(r*2+cc)*32 +: 32] = s;
      end
    return d;
  endfunction

  task automatic run_job(input logic [7:0] kt, input int budget);
    bit h_cmd, h_iss, h_out, h_res, s_resv;
    logic [127:0] nd;
    n_op = 0; n_vin = 0; n_issue = 0; n_overlap = 0; n_resv = 0; n_hold = 0; n_res_cmd = 0;
    acc_cyc = -1; res_cyc = -1; done = 0; res_cap = '0;
    c_log.delete(); idx_log.delete();
    bus.cmd_ktiles   = kt;
    bus.cmd_valid    = 1'b1;
    bus.res_ready    = (res_hold == 0);
    bus.mac_ready_in = (mac_stall == 0);
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      #4;
      nd    = '0;
      h_cmd = bus.cmd_valid && bus.cmd_ready;
      if (h_cmd) acc_cyc = cyc;
      if (bus.op_valid && bus.op_ready) n_op++;
      if (bus.mac_valid_in) n_vin++;
      h_iss = bus.mac_valid_in && bus.mac_ready_in;
      if (h_iss) begin
        n_issue++;
        c_log.push_back(bus.mac_c);
        idx_log.push_back(bus.tile_idx);
        nd = mac_fn(bus.mac_a, bus.mac_b, bus.mac_c);
      end
      if (bus.mac_valid_in && bus.mac_ready_out) n_overlap++;
      h_out  = bus.mac_valid_out && bus.mac_ready_out;
      s_resv = bus.res_valid;
      if (s_resv) begin
        if (res_cyc < 0) begin
          res_cyc = cyc;
          res_cap = bus.res_d;
        end else if (bus.res_d !== res_cap) n_hold++;
        n_resv++;
        if (bus.cmd_ready) n_res_cmd++;
      end
      h_res = bus.res_valid && bus.res_ready;

      @(posedge clk); #1;
      if (h_cmd) bus.cmd_valid = 1'b0;
      if (h_iss) begin pend = 1; pend_cnt = mac_lat; pend_d = nd; end
      if (h_out) begin bus.mac_valid_out = 1'b0; pend = 0; end
      if (pend && !bus.mac_valid_out) begin
        if (pend_cnt == 0) begin
          bus.mac_valid_out = 1'b1;
          bus.mac_d         = pend_d;
        end else pend_cnt--;
      end
      if (mac_stall > 0) mac_stall--;
      bus.mac_ready_in = (mac_stall == 0);
      if (op_rand) bus.op_valid = 1'($urandom_range(0, 1));
      if (s_resv && res_hold > 0) res_hold--;
      bus.res_ready = (res_hold == 0);
      if (early_en && s_resv) begin
        bus.cmd_valid  = 1'b1;
        bus.cmd_ktiles = early_kt;
      end
      if (h_res) done = 1;
      if (abort_issues > 0 && n_issue == abort_issues) break;
    end
    if (abort_issues == 0) chk("job_done", done, 1);
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {bus.cmd_ready, bus.op_ready, bus.mac_valid_in, bus.mac_ready_out,
              bus.res_valid, bus.busy}, 0);
    chk({tag, "_idx"}, bus.tile_idx, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_ktiles = '0;
    bus.op_valid = 1'b1; bus.op_a = A_T; bus.op_b = B_T;
    bus.mac_ready_in = 1'b1; bus.mac_valid_out = 1'b0; bus.mac_d = '0;
    bus.res_ready = 1'b1;

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #4 chk_quiet("rst_outs");
    @(posedge clk); #1 rst = 1'b0;
    #4 chk("rst_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk); #1;

    // single tile, ideal MAC
    mac_lat = 0;
    run_job(8'd1, 50);
    chk("t1_res", res_cap, D1);
    chk("t1_ophs", n_op, 1);
    chk("t1_issues", n_issue, 1);
    chk("t1_c0", c_log[0], 0);
    chk("t1_lat", res_cyc - acc_cyc, 3);

    // three tiles, MAC latency 3
    mac_lat = 3;
    run_job(8'd3, 100);
    chk("t2_res", res_cap, D3);
    chk("t2_ophs", n_op, 3);
    chk("t2_issues", n_issue, 3);
    chk("t2_c", {c_log[2], c_log[1], c_log[0]}, {D2, D1, 128'd0});
    chk("t2_idx", {idx_log[2], idx_log[1], idx_log[0]}, 24'h020100);
    chk("t2_vin_in_wait", n_overlap, 0);
    chk("t2_vin_cycles", n_vin, 3);

    // three tiles, ideal MAC: minimum latency
    mac_lat = 0;
    run_job(8'd3, 100);
    chk("t2b_res", res_cap, D3);
    chk("t2b_lat", res_cyc - acc_cyc, 7);

    // zero tiles
    run_job(8'd0, 20);
    chk("t3_ophs", n_op, 0);
    chk("t3_vin", n_vin, 0);
    chk("t3_lat", res_cyc - acc_cyc, 1);
    chk("t3_res", res_cap, 0);

    // result back-pressure with a command waiting
    res_hold = 5; early_en = 1; early_kt = 8'd2;
    run_job(8'd1, 60);
    early_en = 0;
    chk("t4_res", res_cap, D1);
    chk("t4_hold", n_hold, 0);
    chk("t4_cmd_rdy_in_done", n_res_cmd, 0);
    chk("t4_resv_cycles", n_resv, 6);
    run_job(8'd2, 60);
    chk("t4_accept_cyc", acc_cyc, 0);
    chk("t4b_res", res_cap, D2);

    // random op_valid and MAC issue stall
    op_rand = 1; mac_stall = 4; mac_lat = 1;
    run_job(8'd3, 300);
    op_rand = 0; bus.op_valid = 1'b1;
    chk("t5_ophs", n_op, 3);
    chk("t5_issues", n_issue, 3);
    chk("t5_res", res_cap, D3);
    chk("t5_c", {c_log[2], c_log[1]}, {D2, D1});

    // reset in WAIT, spurious MAC result, then a clean job
    mac_lat = 2; abort_issues = 2;
    run_job(8'd4, 100);
    abort_issues = 0;
    chk("t6_in_wait", bus.mac_ready_out, 1);
    rst = 1'b1;
    #1 chk_quiet("t6_rst_outs");
    pend = 0;
    bus.mac_valid_out = 1'b1; bus.mac_d = '1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) begin
      #4 chk("t6_spurious_rdy", bus.mac_ready_out, 0);
      @(posedge clk); #1;
    end
    bus.mac_valid_out = 1'b0; bus.mac_d = '0;
    mac_lat = 0;
    run_job(8'd1, 50);
    chk("t6_res", res_cap, D1);
    chk("t6_c0", c_log[0], 0);
    chk("t6_ophs", n_op, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/matmul_tile_sequencer.md
MATMUL_TILE_SEQUENCER -- requirements
Module: matmul_tile_sequencer

Interface
REQ-001 Parameter M, default 2: rows of A, C and D tiles.
REQ-002 Parameter N, default 2: columns of B, C and D tiles.
REQ-003 Parameter K, default 2: inner dimension of one tile.
REQ-004 Parameter P, default 8: operand element width; accumulator element width is 4*P.
REQ-005 Parameter CW, default 8: width of the tile-count field and the tile index.
REQ-006 Ports, one per line:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  job request.
- cmd_ready  out  1  job accepted when high together with cmd_valid.
- cmd_ktiles  in  CW  number of K-tiles to accumulate (0..2^CW-1).
- op_valid  in  1  operand tile pair available.
- op_ready  out  1  operand pair consumed.
- op_a  in  M*K*P  flattened A tile, element [r][k] at bits ((r*K+k)*P)+:P.
- op_b  in  K*N*P  flattened B tile, element [k][c] at bits ((k*N+c)*P)+:P.
- tile_idx  out  CW  index of the next K-tile to fetch.
- mac_valid_in  out  1  issue to the MAC.
- mac_ready_in  in  1  MAC accepts the issue.
- mac_a  out  M*K*P  A tile to the MAC.
- mac_b  out  K*N*P  B tile to the MAC.
- mac_c  out  M*N*4*P  accumulator input to the MAC.
- mac_valid_out  in  1  MAC result valid.
- mac_ready_out  out  1  sequencer accepts the MAC result.
- mac_d  in  M*N*4*P  MAC result D = A*B + C.
- res_valid  out  1  final result valid.
- res_ready  in  1  result consumer ready.
- res_d  out  M*N*4*P  final accumulated tile.
- busy  out  1  high in any state other than IDLE.

Function
REQ-007 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-008 IDLE: cmd_ready=1. On cmd_valid&&cmd_ready: latch cmd_ktiles into ktiles, set acc=0 and tile_cnt=0, then go to DONE if cmd_ktiles==0, otherwise go to ISSUE.
REQ-009 ISSUE: mac_valid_in=op_valid, op_ready=mac_ready_in, mac_a=op_a, mac_b=op_b, mac_c=acc, all combinational pass-through. On op_valid&&mac_ready_in go to WAIT.
REQ-010 WAIT: mac_ready_out=1. On mac_valid_out: acc<=mac_d and tile_cnt<=tile_cnt+1; go to DONE if tile_cnt+1==ktiles, otherwise go to ISSUE.
REQ-011 DONE: res_valid=1 and res_d=acc, both held stable until res_ready. On res_ready go to IDLE.
REQ-012 At most one MAC transaction is in flight, because each issue depends on the previous D; MAC pipeline latency is arbitrary (>=0 cycles).
REQ-013 Outside ISSUE, mac_valid_in=0 and op_ready=0. Outside WAIT, mac_ready_out=0, so a spurious mac_valid_out stays back-pressured and never updates acc. Outside DONE, res_valid=0. Outside IDLE, cmd_ready=0.
REQ-014 tile_idx=tile_cnt at all times; it is valid for operand prefetch during ISSUE.
REQ-015 acc is an M*N*4*P register written only from mac_d, with no saturation; wrap-around is inherited from the MAC.
REQ-016 A new command is accepted at the earliest in the cycle after the DONE handshake, because the FSM has already returned to IDLE.
REQ-017 Minimum job latency from cmd accept to res_valid is 2*ktiles+1 cycles when the MAC has zero latency and op_valid, mac_ready_in and mac_valid_out are always high; for ktiles==0 it is 1 cycle.
REQ-018 mac_c and mac_a/mac_b are not registered; all output-only valid/ready signals are decoded from the state.

Reset
REQ-019 rst_i asserted at any time (asynchronous) forces: state=IDLE, acc=0, tile_cnt=0, ktiles=0.
REQ-020 During rst_i: cmd_ready=0, op_ready=0, mac_valid_in=0, mac_ready_out=0, res_valid=0 and busy=0. cmd_ready rises in the first cycle after rst_i deasserts.
REQ-021 Reset mid-job (ISSUE, WAIT or DONE) abandons the job with no result produced; any in-flight MAC result is the MAC's own responsibility to flush.

Verification
REQ-022 Single tile: M=N=K=2, ktiles=1, A=[[1,2],[3,4]], B=[[5,6],[7,8]], ideal MAC -> mac_c=0 on issue; res_d=[[19,22],[43,50]]; exactly one op handshake.
REQ-023 Three tiles of the same A/B, MAC latency 3 -> mac_c on issues 2 and 3 equals the prior D; res_d=[[57,66],[129,150]]; tile_idx steps 0,1,2; mac_valid_in never high while waiting.
REQ-024 ktiles=0 -> no op_ready and no mac_valid_in; res_valid the next cycle with res_d=0.
REQ-025 Back-pressure: res_ready low for 5 cycles -> res_valid and res_d held stable and cmd_ready=0; a command presented during that window is accepted only after return to IDLE.
REQ-026 op_valid toggling randomly and mac_ready_in low for 4 cycles -> no lost or duplicated tiles; op handshakes equal ktiles.
REQ-027 rst_i pulsed in WAIT of a 4-tile job, followed by a spurious mac_valid_out -> outputs take reset values in the same cycle, acc=0, and the next job (ktiles=1) gives the correct result.
